hazard_ctrl: RTL and testbench

- Hazard detection and stall/flush sequencer for the 5-stage MIPS pipeline; sits beside the forwarding unit.
- Covers the cases forwarding cannot resolve:
  - load-use;
  - branch operands in ID produced by EX or by a load in MEM;
  - structural/data hazards on the multi-cycle mult/div unit, which it tracks with an occupancy FSM.
- Drives PC write enable, IF/ID write enable and the IF/ID and ID/EX flushes.

---
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl_if - ID/EX/MEM hazard inputs and stall/flush controls   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface hazard_ctrl_if
`ifdef HAZARD_STATS_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] registerRsID;
  logic [4:0] registerRtID;
  logic       usesRsID;
  logic       usesRtID;
  logic       isBranchID;
  logic       branchTakenID;
  logic       jumpID;
  logic       mdStartID;
  logic       mdReadID;
  logic [4:0] registerRdEX;
  logic       regWriteEX;
  logic       memReadEX;
  logic [4:0] registerRdMEM;
  logic       memReadMEM;
  logic       pcWrite;
  logic       ifidWrite;
  logic       ifidFlush;
  logic       idexFlush;
  logic       mdBusy;
  logic       mdAccept;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;
`endif

  modport slave (
    input  registerRsID, registerRtID, usesRsID, usesRtID,
    input  isBranchID, branchTakenID, jumpID, mdStartID, mdReadID,
    input  registerRdEX, regWriteEX, memReadEX, registerRdMEM, memReadMEM,
`ifdef HAZARD_STATS_EN
    output stallCount, flushCount,
`endif
    output pcWrite, ifidWrite, ifidFlush, idexFlush, mdBusy, mdAccept
  );

  modport master (
    output registerRsID, registerRtID, usesRsID, usesRtID,
    output isBranchID, branchTakenID, jumpID, mdStartID, mdReadID,
    output registerRdEX, regWriteEX, memReadEX, registerRdMEM, memReadMEM,
`ifdef HAZARD_STATS_EN
    input  stallCount, flushCount,
`endif
    input  pcWrite, ifidWrite, ifidFlush, idexFlush, mdBusy, mdAccept
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl - MIPS stall/flush sequencer with mult/div occupancy;  |
// | HAZARD_STATS_EN adds stall/flush counters.            Rev 1.0      |
// +--------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  localparam logic [3:0] c_MD_LAT = 4'(MD_LATENCY);

  md_state_t  r_state;
  md_state_t  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_matchEX;
  logic w_matchMEM;
  logic w_loadUse;
  logic w_brEX;
  logic w_brLoad;
  logic w_mdHaz;
  logic w_stall;
  logic w_mdBusy;
  logic w_mdAccept;
  logic w_ifidFlush;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_matchEX  = (bus.registerRdEX != 5'd0) &&
                      ((bus.usesRsID && (bus.registerRdEX == bus.registerRsID)) ||
                       (bus.usesRtID && (bus.registerRdEX == bus.registerRtID)));
  assign w_matchMEM = (bus.registerRdMEM != 5'd0) &&
                      ((bus.usesRsID && (bus.registerRdMEM == bus.registerRsID)) ||
                       (bus.usesRtID && (bus.registerRdMEM == bus.registerRtID)));

  assign w_loadUse  = bus.memReadEX && w_matchEX;
  assign w_brEX     = bus.isBranchID && bus.regWriteEX && w_matchEX;
  assign w_brLoad   = bus.isBranchID && bus.memReadMEM && w_matchMEM;
  assign w_mdBusy   = (r_state == S_BUSY);
  assign w_mdHaz    = w_mdBusy && (bus.mdStartID || bus.mdReadID);
  assign w_stall    = w_loadUse || w_brEX || w_brLoad || w_mdHaz;
  assign w_mdAccept = bus.mdStartID && !w_stall;

  // A stalled branch/jump has not resolved yet, so it must not squash IF.
  assign w_ifidFlush = !w_stall &&
                       ((bus.branchTakenID && bus.isBranchID) || bus.jumpID);

  assign bus.pcWrite   = !w_stall;
  assign bus.ifidWrite = !w_stall;
  assign bus.idexFlush = w_stall;
  assign bus.ifidFlush = w_ifidFlush;
  assign bus.mdBusy    = w_mdBusy;
  assign bus.mdAccept  = w_mdAccept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mdAccept) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = c_MD_LAT;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_stall)     r_stallCount <= r_stallCount + 1'b1;
      if (w_ifidFlush) r_flushCount <= r_flushCount + 1'b1;
    end
  end

  assign bus.stallCount = r_stallCount;
  assign bus.flushCount = r_flushCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl - scoreboard bench for hazard_ctrl                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_hazard_ctrl;

  // {pcWrite, ifidWrite, ifidFlush, idexFlush, mdBusy, mdAccept}
  localparam logic [5:0] c_NRM  = 6'b110000;
  localparam logic [5:0] c_STL  = 6'b000100;
  localparam logic [5:0] c_FLS  = 6'b111000;
  localparam logic [5:0] c_ACC  = 6'b110001;
  localparam logic [5:0] c_BSY  = 6'b110010;
  localparam logic [5:0] c_BSTL = 6'b000110;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  sb_t  sb[$];
  sb_t  r_e;

`ifdef HAZARD_STATS_EN
  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(hif.slave));
`else
  hazard_ctrl_if hif ();
  hazard_ctrl #(.MD_LATENCY(4)) dut (.clk(clk), .reset(reset), .bus(hif.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic rst_v,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic br, input logic tk, input logic jmp, input logic mds, input logic mdr,
                       input logic [4:0] rdex, input logic rwex, input logic mrex,
                       input logic [4:0] rdmem, input logic mrmem, input logic [5:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    reset                 = rst_v;
    hif.registerRsID      = rs;
    hif.registerRtID      = rt;
    hif.usesRsID          = urs;
    hif.usesRtID          = urt;
    hif.isBranchID        = br;
    hif.branchTakenID     = tk;
    hif.jumpID            = jmp;
    hif.mdStartID         = mds;
    hif.mdReadID          = mdr;
    hif.registerRdEX      = rdex;
    hif.regWriteEX        = rwex;
    hif.memReadEX         = mrex;
    hif.registerRdMEM     = rdmem;
    hif.memReadMEM        = mrmem;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      r_e = sb.pop_front();
      chk(r_e.tag,
          {26'd0, hif.pcWrite, hif.ifidWrite, hif.ifidFlush, hif.idexFlush, hif.mdBusy, hif.mdAccept},
          {26'd0, r_e.exp});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    // args: tag rst  rs rt urs urt br tk jmp mds mdr  rdEX rwEX mrEX  rdMEM mrMEM  exp
    drive("rst_hold",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    drive("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    drive("ld_use",       0, 8, 1, 1, 0, 0, 0, 0, 0, 0,  8, 1, 1,  0, 0, c_STL);
    drive("ld_use_done",  0, 8, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  8, 1, c_NRM);
    drive("rd0_no_stall", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1,  0, 0, c_NRM);
    drive("rt_use",       0, 3, 5, 1, 1, 0, 0, 0, 0, 0,  5, 1, 1,  0, 0, c_STL);
    drive("rt_unused",    0, 3, 5, 1, 0, 0, 0, 0, 0, 0,  5, 1, 1,  0, 0, c_NRM);
    drive("br_alu_ex",    0, 8, 2, 1, 1, 1, 1, 0, 0, 0,  8, 1, 0,  0, 0, c_STL);
    drive("br_alu_go",    0, 8, 2, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0,  8, 0, c_FLS);
    drive("br_ld_ex",     0, 8, 2, 1, 1, 1, 1, 0, 0, 0,  8, 1, 1,  0, 0, c_STL);
    drive("br_ld_mem",    0, 8, 2, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0,  8, 1, c_STL);
    drive("br_ld_go",     0, 8, 2, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0,  0, 0, c_FLS);
    drive("br_rt_mem",    0, 4, 9, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0,  9, 1, c_STL);
    drive("br_not_taken", 0, 8, 2, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    drive("jr_ld_stall",  0, 8, 0, 1, 0, 0, 0, 1, 0, 0,  8, 1, 1,  0, 0, c_STL);
    drive("jump",         0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 0, c_FLS);
    // mult accepted, mflo waits out MD_LATENCY busy cycles
    drive("md_acc",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, c_ACC);
    for (int i = 0; i < 4; i++)
      drive("mflo_wait",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_BSTL);
    drive("mflo_go",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_NRM);
    // second mult arrives at t+2
    drive("md_acc2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, c_ACC);
    drive("md2_busy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_BSY);
    for (int i = 0; i < 3; i++)
      drive("md2_wait",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, c_BSTL);
    drive("md2_go",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, c_ACC);
    // load-use coinciding with mdHaz: counter keeps running
    drive("lu_md",        0, 7, 0, 1, 0, 0, 0, 0, 0, 1,  7, 1, 1,  0, 0, c_BSTL);
    for (int i = 0; i < 3; i++)
      drive("lu_md_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_BSTL);
    drive("lu_md_go",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_NRM);
    // reset in the middle of BUSY
    drive("md_acc3",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, c_ACC);
    drive("md3_busy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_BSY);
    drive("md3_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_NRM);
    drive("mflo_post_rst",0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, c_NRM);
`ifdef HAZARD_STATS_EN
    drive("st_rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    @(negedge clk);
    #1;
    chk("stall_cnt_rst", hif.stallCount, 32'd0);
    chk("flush_cnt_rst", hif.flushCount, 32'd0);
    for (int i = 0; i < 3; i++)
      drive("st_stall",   0, 8, 0, 1, 0, 0, 0, 0, 0, 0,  8, 1, 1,  0, 0, c_STL);
    for (int i = 0; i < 2; i++)
      drive("st_flush",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 0, c_FLS);
    drive("st_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    @(negedge clk);
    #1;
    chk("stall_cnt", hif.stallCount, 32'd3);
    chk("flush_cnt", hif.flushCount, 32'd2);
    drive("st_rst2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, c_NRM);
    @(negedge clk);
    #1;
    chk("stall_cnt_rst2", hif.stallCount, 32'd0);
    chk("flush_cnt_rst2", hif.flushCount, 32'd0);
`endif
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0)
      chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
